// File: rtl/radix32_input_reorder.sv
// radix32_input_reorder: ping-pong 9-sample buffer emitting stride-3 triplets for a radix-3^2 FFT
module radix32_input_reorder #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic [DW-1:0] a_re,
  output logic [DW-1:0] a_img,
  output logic [DW-1:0] b_re,
  output logic [DW-1:0] b_img,
  output logic [DW-1:0] c_re,
  output logic [DW-1:0] c_img,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic          sync_err
);
  logic [DW-1:0] mem_re  [2][9];
  logic [DW-1:0] mem_img [2][9];
  logic [1:0] full, set_f, clr_f, rd_k, k;
  logic [3:0] wr_cnt, wr_idx, ia, ib, ic;
  logic wr_bank, rd_bank, rd_busy, fire, resync, emit, wr_done, rd_done;
  // handshake, write index and read index decode; idle with a full bank emits k=0 directly
  always_comb begin
    in_ready = !rst && !full[wr_bank];
    fire = in_valid && in_ready;
    resync = fire && in_sof && wr_cnt != 4'd0;
    wr_idx = in_sof ? 4'd0 : wr_cnt;
    wr_done = fire && wr_idx == 4'd8;
    emit = full[rd_bank];
    k = rd_busy ? rd_k : 2'd0;
    rd_done = emit && k == 2'd2;
    ia = {2'b00, k};
    ib = ia + 4'd3;
    ic = ia + 4'd6;
    set_f = {2{wr_done}} & (wr_bank ? 2'b10 : 2'b01);
    clr_f = {2{rd_done}} & (rd_bank ? 2'b10 : 2'b01);
  end
  // sample storage; contents are don't-care until a bank is marked full
  always_ff @(posedge clk) begin
    if (fire) begin
      mem_re[wr_bank][wr_idx] <= in_re;
      mem_img[wr_bank][wr_idx] <= in_img;
    end
  end
  // framing, bank flags and registered triplet outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_k <= '0;
      rd_busy <= 1'b0;
      sync_err <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      a_re <= '0;
      a_img <= '0;
      b_re <= '0;
      b_img <= '0;
      c_re <= '0;
      c_img <= '0;
    end else begin
      full <= (full | set_f) & ~clr_f;
      sync_err <= resync;
      if (fire) begin
        wr_cnt <= wr_done ? 4'd0 : wr_idx + 4'd1;
        if (wr_done) wr_bank <= !wr_bank;
      end
      out_valid <= emit;
      out_first <= emit && k == 2'd0;
      out_last <= rd_done;
      if (emit) begin
        a_re <= mem_re[rd_bank][ia];
        a_img <= mem_img[rd_bank][ia];
        b_re <= mem_re[rd_bank][ib];
        b_img <= mem_img[rd_bank][ib];
        c_re <= mem_re[rd_bank][ic];
        c_img <= mem_img[rd_bank][ic];
        rd_busy <= !rd_done;
        rd_k <= rd_done ? 2'd0 : k + 2'd1;
        if (rd_done) rd_bank <= !rd_bank;
      end
    end
  end
endmodule

// File: tb/tb_radix32_input_reorder.sv
// tb_radix32_input_reorder: scoreboard bench for the stride-3 input commutator
module tb_radix32_input_reorder;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] in_re = '0, in_img = '0;
  logic in_valid = 1'b0, in_sof = 1'b0;
  logic in_ready, out_valid, out_first, out_last, sync_err;
  logic [DW-1:0] a_re, a_img, b_re, b_img, c_re, c_img;
  typedef struct packed {
    logic [DW-1:0] ar, ai, br, bi, cr, ci;
    logic f, l;
  } trip_t;
  trip_t q[$];
  trip_t g, e;
  int total = 0, bad = 0, cyc = 0, vcnt = 0, sync_cnt = 0, exp_sync = 0, stalls = 0;
  int t_acc = 0, t_first = -1, m_cnt = 0;
  int v0, s0, e0;
  logic [DW-1:0] m_re [9];
  logic [DW-1:0] m_img [9];

  radix32_input_reorder #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_re(in_re), .in_img(in_img), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .a_re(a_re), .a_img(a_img), .b_re(b_re),
    .b_img(b_img), .c_re(c_re), .c_img(c_img), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $error("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (sync_err) sync_cnt++;
    if (out_valid) begin
      vcnt++;
      g = {a_re, a_img, b_re, b_img, c_re, c_img, out_first, out_last};
      if (out_first) t_first = cyc;
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL trip_unexpected got=%h exp=none", g);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        assert (g === e) else begin
          bad++;
          $error("FAIL trip got=%h exp=%h", g, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [DW-1:0] re, input logic [DW-1:0] img, input logic sof);
    if (sof && m_cnt != 0) begin
      exp_sync++;
      m_cnt = 0;
    end
    m_re[m_cnt] = re;
    m_img[m_cnt] = img;
    m_cnt++;
    if (m_cnt == 9) begin
      for (int k = 0; k < 3; k++)
        q.push_back(trip_t'{m_re[k], m_img[k], m_re[k+3], m_img[k+3], m_re[k+6], m_img[k+6],
                            k == 0, k == 2});
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] img, input logic sof);
    bit acc;
    in_re = re;
    in_img = img;
    in_sof = sof;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      #1 acc = in_ready;
      if (!acc) stalls++;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        model(re, img, sof);
        t_acc = cyc;
        break;
      end
      if (t == 49) begin
        total++;
        bad++;
        $error("FAIL send_timeout got=stalled exp=accepted");
      end
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", {out_valid, out_first, out_last, sync_err}, 0);
    chk("rst_data", |{a_re, a_img, b_re, b_img, c_re, c_img}, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1);
    @(negedge clk);

    v0 = vcnt;
    for (int i = 0; i < 9; i++) send(i, 100 + i, i == 0);
    idle(6);
    chk("t1_latency", t_first - t_acc, 1);
    chk("t1_valid_cycles", vcnt - v0, 3);
    chk("t1_hold_a_re", a_re, 2);
    chk("t1_hold_c_img", c_img, 108);
    chk("t1_drain", q.size(), 0);

    v0 = vcnt;
    s0 = stalls;
    for (int f = 0; f < 5; f++)
      for (int i = 0; i < 9; i++) send(1000 + f * 9 + i, $urandom, i == 0);
    idle(6);
    chk("t2_stalls", stalls - s0, 0);
    chk("t2_valid_cycles", vcnt - v0, 15);
    chk("t2_drain", q.size(), 0);

    v0 = vcnt;
    s0 = stalls;
    for (int i = 0; i < 18; i++) send(2000 + i, 3000 + i, i == 0 || i == 9);
    idle(6);
    chk("t3_stalls", stalls - s0, 0);
    chk("t3_valid_cycles", vcnt - v0, 6);
    chk("t3_drain", q.size(), 0);

    s0 = sync_cnt;
    e0 = exp_sync;
    for (int i = 1; i <= 4; i++) send(i, 100 + i, i == 1);
    send(50, 150, 1'b1);
    for (int i = 51; i <= 58; i++) send(i, 100 + i, 1'b0);
    idle(6);
    chk("t4_sync_pulses", sync_cnt - s0, exp_sync - e0);
    chk("t4_sync_one", sync_cnt - s0, 1);
    chk("t4_drain", q.size(), 0);

    for (int i = 0; i < 9; i++) send(500 + i, 600 + i, i == 0);
    for (int i = 0; i < 20 && !(out_valid && !out_first && !out_last); i++) @(negedge clk);
    chk("t5_at_k1", {out_valid, out_first, out_last}, 3'b100);
    #2 rst = 1'b1;
    q.delete();
    m_cnt = 0;
    @(negedge clk);
    chk("t5_rst_ctrl", {out_valid, out_first, out_last, sync_err}, 0);
    chk("t5_rst_data", |{a_re, a_img, b_re, b_img, c_re, c_img}, 0);
    chk("t5_rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    v0 = vcnt;
    idle(5);
    chk("t5_no_stale", vcnt - v0, 0);
    for (int i = 0; i < 9; i++) send(700 + i, 800 + i, i == 0);
    idle(6);
    chk("t5_fresh_cycles", vcnt - v0, 3);
    chk("t5_drain", q.size(), 0);

    v0 = vcnt;
    for (int f = 0; f < 20; f++)
      for (int i = 0; i < 9; i++) begin
        idle($urandom_range(0, 2));
        send($urandom, $urandom, i == 0);
      end
    idle(8);
    chk("t6_valid_cycles", vcnt - v0, 60);
    chk("t6_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
